// File: rtl/mul_pkg.sv
// Shared types and Booth radix-4 digit decoding for the sequential multiplier.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESOLVE,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } sel_e;

    // Map a 3-bit overlapping multiplier window to a partial-product select.
    function automatic sel_e booth_decode(input logic [2:0] bits);
        sel_e sel;
        case (bits)
            3'b001, 3'b010: sel = PM;
            3'b011:         sel = P2M;
            3'b100:         sel = N2M;
            3'b101, 3'b110: sel = NM;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/csa_row.sv
// N-bit 3:2 carry-save row; the carry vector is returned already weighted (shifted left by one).
module csa_row #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] s,
    output logic [N-1:0] c
);

    logic [N-1:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x & y) | (x & z) | (y & z);
    assign c   = maj << 1;

endmodule

// File: rtl/booth_csa_mul_seq.sv
// Iterative signed multiplier: one radix-4 Booth partial product per cycle into a
// carry-save accumulator, then a single carry-propagate add into hi/lo.
module booth_csa_mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned EW    = WIDTH + 2;
    localparam int unsigned ITERS = WIDTH / 2;

    state_e           state;
    state_e           state_next;
    logic             load_c;
    logic             step_c;
    logic             resolve_c;
    logic             last_c;

    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   q;
    logic [CNT_W-1:0] count;
    logic [PW-1:0]    acc_s;
    logic [PW-1:0]    acc_c;
    logic [PW-1:0]    csa_s;
    logic [PW-1:0]    csa_c;

    sel_e             sel_c;
    logic [EW-1:0]    m_ext_c;
    logic [EW-1:0]    pp_base_c;
    logic [PW-1:0]    pp_c;

    assign last_c = (count == CNT_W'(ITERS - 1));

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        resolve_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                resolve_c  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Booth partial product: two extra sign bits keep -2M exact for the most negative M.
    always_comb begin
        m_ext_c = {{2{m[WIDTH-1]}}, m};
        sel_c   = booth_decode(q[2:0]);
        case (sel_c)
            PM:      pp_base_c = m_ext_c;
            P2M:     pp_base_c = m_ext_c << 1;
            NM:      pp_base_c = -m_ext_c;
            N2M:     pp_base_c = -(m_ext_c << 1);
            default: pp_base_c = '0;
        endcase
        pp_c = {{(PW - EW){pp_base_c[EW-1]}}, pp_base_c} << {count, 1'b0};
    end

    csa_row #(
        .N(PW)
    ) u_csa_row (
        .x(acc_s),
        .y(acc_c),
        .z(pp_c),
        .s(csa_s),
        .c(csa_c)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            m     <= '0;
            q     <= '0;
            count <= '0;
            acc_s <= '0;
            acc_c <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (load_c) begin
                m     <= a;
                q     <= {b, 1'b0};
                count <= '0;
                acc_s <= '0;
                acc_c <= '0;
            end else if (step_c) begin
                acc_s <= csa_s;
                acc_c <= csa_c;
                q     <= {q[WIDTH], q[WIDTH], q[WIDTH:2]};
                count <= count + CNT_W'(1);
            end
            if (resolve_c) begin
                {hi, lo} <= acc_s + acc_c;
            end
        end
    end

endmodule

// File: tb/tb_booth_csa_mul_seq.sv
// Scoreboard bench: a cycle-level model queues signed products on accepted starts,
// and a monitor checks busy/done timing, results and hold behaviour every cycle.
module tb_booth_csa_mul_seq;

    localparam int unsigned W   = 32;
    localparam int          LAT = W / 2 + 2;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic [2*W-1:0] sb_q[$];
    int             rem        = 0;
    logic           model_busy = 1'b0;
    logic           model_done = 1'b0;
    logic [2*W-1:0] last_res   = '0;
    logic [2*W-1:0] want;
    int             n_cmp      = 0;
    int             n_bad      = 0;
    logic           finish_req = 1'b0;

    booth_csa_mul_seq dut (
        .clock(clock),
        .clear(clear),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    always #5 clock = ~clock;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h8000_0000;
            1:       v = 32'h7fff_ffff;
            2:       v = '0;
            3:       v = '1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Reference timing: an accepted start keeps the unit busy for LAT edges, done on the last busy one.
    always @(posedge clock or posedge clear) begin
        if (clear) begin
            rem = 0;
        end else if (rem == 0 && start) begin
            sb_q.push_back(ref_prod(a, b));
            rem = LAT;
        end else if (rem > 0) begin
            rem = rem - 1;
        end
        model_busy = (rem != 0);
        model_done = (rem == 1);
    end

    task automatic check(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clock or posedge clear) begin
        #1;
        if (clear) begin
            last_res = '0;
            sb_q.delete();
        end
        check("busy", 64'(busy), 64'(model_busy));
        check("done", 64'(done), 64'(model_done));
        if (model_done && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL product: got %h want none queued at %0t", {hi, lo}, $time);
            end else begin
                want = sb_q.pop_front();
                check("product", {hi, lo}, want);
                last_res = want;
            end
        end else begin
            check("hold", {hi, lo}, last_res);
        end
        if (finish_req) begin
            n_cmp++;
            if (sb_q.size() != 0) begin
                n_bad++;
                $display("FAIL drain: got %0d pending want 0", sb_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clock);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clock);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        repeat (LAT + 2) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        clear = 1'b0;

        op(32'd6, 32'd7);
        op(32'hffff_fffb, 32'd3);
        op(32'hffff_ffff, 32'hffff_ffff);
        op(32'h8000_0000, 32'h8000_0000);
        op(32'h8000_0000, 32'h7fff_ffff);

        // start held high with operands changing every cycle
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            start = 1'b1;
            a     = rand_operand();
            b     = rand_operand();
        end
        @(negedge clock);
        start = 1'b0;
        repeat (LAT + 3) @(negedge clock);

        // asynchronous clear in the middle of the iterations
        @(negedge clock);
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(posedge clock);
        #3 clear = 1'b1;
        #2 clear = 1'b0;
        repeat (3) @(negedge clock);
        op(32'd3, 32'd4);

        for (int i = 0; i < 40000; i++) begin
            @(negedge clock);
            start = ($urandom_range(0, 3) != 0);
            a     = rand_operand();
            b     = rand_operand();
        end
        @(negedge clock);
        start = 1'b0;
        repeat (LAT + 5) @(negedge clock);
        finish_req = 1'b1;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no finish want finish by %0t", $time);
        $fatal(1, "simulation timeout");
    end

endmodule
